lsu_dmem_ctrl: RTL and testbench
================================

Name: lsu_dmem_ctrl

Overview:
Load/store controller between the core's memory stage and the 64-bit byte-addressed data memory. The data memory reads combinationally and writes a full doubleword while its write enable is high.
- Accepts one byte/half/word/doubleword request at a time.
- Drives doubleword-aligned memory accesses.
- Stores narrower than 64 bits use read-modify-write.
- Returns sign- or zero-extended load data over a valid/ready response handshake.

Parameters:
- DATA_WIDTH, 64, data and address width; fixed at 64, other values unsupported.
- MEM_BYTES, 1048576, memory size in bytes; accesses beyond it fault.

Ports:
- in_clk  input  1  clock, rising edge.
- in_rst  input  1  asynchronous, active-high reset.
- in_req_valid  input  1  request present.
- out_req_ready  output  1  controller idle and can accept a request.
- in_req_we  input  1  1=store, 0=load.
- in_req_size  input  2  0=byte, 1=half, 2=word, 3=double.
- in_req_unsigned  input  1  zero-extend load result (ignored for double and stores).
- in_req_addr  input  64  byte address.
- in_req_wdata  input  64  store data, right-justified.
- out_resp_valid  output  1  response available.
- in_resp_ready  input  1  core consumes the response.
- out_resp_rdata  output  64  extended load data; 0 for stores and faults.
- out_resp_fault  output  2  0=ok, 1=misaligned, 2=out of range.
- out_mem_addr  output  64  doubleword-aligned address to memory.
- out_mem_data  output  64  write data to memory.
- out_mem_wr_en  output  1  memory write enable.
- in_mem_data  input  64  memory read data (combinational from out_mem_addr).

Behaviour:
- Reset values:
  - State IDLE.
  - out_req_ready=1, out_resp_valid=0, out_resp_rdata=0, out_resp_fault=0.
  - out_mem_addr=0, out_mem_data=0, out_mem_wr_en=0.
  - All request capture registers cleared.
- out_mem_wr_en is a registered output. Reset mid-WR drops it immediately (asynchronous).
- out_req_ready = (state==IDLE). A request is accepted on a rising edge with valid&&ready; addr, size, we, unsigned and wdata are captured.
- Fault checks at accept, in this priority:
  - Misaligned: addr[size-1:0] != 0.
  - Out of range: (addr & ~7) + 7 >= MEM_BYTES.
  - Faulting requests go IDLE->RESP with no memory access and no write.
- States:
  - IDLE: waits for an accepted request.
  - RD: out_mem_addr = captured addr & ~7. in_mem_data is latched at the end of the cycle.
  - WR: out_mem_wr_en=1 for exactly one cycle. Address and merged data are stable for the whole cycle.
  - RESP: out_resp_valid=1, held with data/fault stable until in_resp_ready. Then return to IDLE; a new request may be accepted on the following edge.
- Transitions:
  - Load: IDLE->RD->RESP.
  - Store of size 0..2: IDLE->RD->WR->RESP.
  - Store of size 3: IDLE->WR->RESP, with no read.
- Latency from the accept edge T to the first response cycle:
  - Load: T+2.
  - Narrow store: T+3.
  - Double store: T+2.
  - Fault: T+1.
- Lane rule: offset = addr[2:0].
  - Load extracts bytes [offset, offset+2^size), shifted down, then sign-extended from the top bit unless unsigned or size==3.
  - Store merge replaces exactly those bytes of the latched doubleword with the low 2^size bytes of wdata; all other bytes are unchanged.
- out_mem_addr and out_mem_data keep their last value outside RD/WR. Memory is never written outside WR.
- in_req_valid while not ready is ignored; the requester must hold it until accepted.

Decomposition:
- Package lsu_pkg holds:
  - Size encodings SZ_B/SZ_H/SZ_W/SZ_D.
  - Fault codes FLT_NONE/FLT_MISALIGN/FLT_RANGE.
  - State encoding IDLE/RD/WR/RESP.
- One combinational sub-module, lsu_lane_align: inputs are doubleword, offset, size, unsigned and wdata; outputs are the extended load value and the merged store doubleword. It is shared by the RD and WR paths.

Test Plan:
- Preload mem[0x100..0x107]=0x8877665544332211, load byte addr 0x107 signed -> rdata=0xFFFFFFFFFFFFFF88 at T+2; same access unsigned -> 0x88.
- Store half 0xBEEF at 0x102 over the above contents -> exactly one wr_en cycle at T+2 with data 0x88776655BEEF2211; response at T+3; a following double load at 0x100 returns the same value.
- Store double 0x0123456789ABCDEF at 0x200 -> no RD state, wr_en at T+1, response at T+2.
- Load word at 0x103 -> fault=1, rdata=0, response at T+1, no memory access; load double at 0xFFFF8 -> ok; load double at 0x100000 -> fault=2.
- Hold in_resp_ready=0 for 5 cycles -> resp_valid and rdata stay stable, req_ready=0; a back-to-back request is accepted only after the handshake completes.
- Assert in_rst during the WR cycle -> wr_en falls within the same cycle, outputs return to reset values, state IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, fault codes and
// controller states, plus a helper giving the low address bits that must be
// zero for a naturally aligned access of a given size.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [1:0] FLT_NONE     = 2'd0;
  localparam logic [1:0] FLT_MISALIGN = 2'd1;
  localparam logic [1:0] FLT_RANGE    = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_e;

  // Address bits that must be zero for an access of 2^size bytes.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      SZ_B:    align_mask = 3'b000;
      SZ_H:    align_mask = 3'b001;
      SZ_W:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Purpose: byte-lane alignment between a doubleword and a narrow access.
// Latency: purely combinational.
// Backpressure: none; used inside the controller's RD/WR datapath.
// Ports: dword (memory doubleword), offset (addr[2:0]), size, is_unsigned,
//        wdata (right-justified store data) -> load_data (extended load value),
//        store_data (dword with the accessed lanes replaced by wdata).
import lsu_pkg::*;

module lsu_lane_align (
  input  logic [63:0] dword,
  input  logic [2:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] store_data
);

  logic [63:0] shifted;
  logic [63:0] wshift;
  logic [7:0]  lane_mask;

  always_comb begin
    shifted   = dword >> {offset, 3'b000};
    wshift    = wdata << {offset, 3'b000};
    load_data = shifted;
    lane_mask = 8'hFF;
    case (size)
      SZ_B: begin
        load_data = is_unsigned ? {56'd0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
        lane_mask = 8'h01;
      end
      SZ_H: begin
        load_data = is_unsigned ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
        lane_mask = 8'h03;
      end
      SZ_W: begin
        load_data = is_unsigned ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
        lane_mask = 8'h0F;
      end
      default: begin
        load_data = shifted;
        lane_mask = 8'hFF;
      end
    endcase
    // Accesses are naturally aligned, so the shifted mask never spills past lane 7.
    lane_mask  = lane_mask << offset;
    store_data = dword;
    for (int i = 0; i < 8; i++) begin
      if (lane_mask[i]) store_data[8*i +: 8] = wshift[8*i +: 8];
    end
  end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Purpose: load/store controller driving doubleword-aligned data memory, RMW for narrow stores.
// Latency: accept->response 2 cycles load / double store, 3 narrow store, 1 on fault.
// Backpressure: one request in flight; req_ready low until the response handshake completes.
// Ports: in_clk/in_rst; request in_req_* with out_req_ready; response out_resp_*
//        with in_resp_ready; memory out_mem_addr/out_mem_data/out_mem_wr_en, in_mem_data.
import lsu_pkg::*;

module lsu_dmem_ctrl #(
  parameter int          DATA_WIDTH = 64,
  parameter logic [63:0] MEM_BYTES  = 64'd1048576
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_req_valid,
  output logic                  out_req_ready,
  input  logic                  in_req_we,
  input  logic [1:0]            in_req_size,
  input  logic                  in_req_unsigned,
  input  logic [DATA_WIDTH-1:0] in_req_addr,
  input  logic [DATA_WIDTH-1:0] in_req_wdata,
  output logic                  out_resp_valid,
  input  logic                  in_resp_ready,
  output logic [DATA_WIDTH-1:0] out_resp_rdata,
  output logic [1:0]            out_resp_fault,
  output logic [DATA_WIDTH-1:0] out_mem_addr,
  output logic [DATA_WIDTH-1:0] out_mem_data,
  output logic                  out_mem_wr_en,
  input  logic [DATA_WIDTH-1:0] in_mem_data
);

  state_e      state_q, state_d;

  // Captured request. The upper address bits live in out_mem_addr, which is
  // loaded at accept so it is already valid during the RD/WR cycle.
  logic [2:0]  req_off_q;
  logic [1:0]  req_size_q;
  logic        req_we_q;
  logic        req_uns_q;
  logic [63:0] req_wdata_q;

  logic        accept;
  logic        misalign;
  logic        out_of_range;
  logic [64:0] line_end;
  logic [1:0]  req_fault;
  logic [63:0] load_data;
  logic [63:0] store_data;

  assign accept = in_req_valid && out_req_ready;

  // Checked on the incoming request; misalignment takes priority over range.
  assign misalign     = |(in_req_addr[2:0] & align_mask(in_req_size));
  assign line_end     = {1'b0, in_req_addr[63:3], 3'b000} + 65'd7;
  assign out_of_range = line_end >= {1'b0, MEM_BYTES};
  assign req_fault    = misalign ? FLT_MISALIGN : (out_of_range ? FLT_RANGE : FLT_NONE);

  lsu_lane_align u_lane_align (
    .dword       (in_mem_data),
    .offset      (req_off_q),
    .size        (req_size_q),
    .is_unsigned (req_uns_q),
    .wdata       (req_wdata_q),
    .load_data   (load_data),
    .store_data  (store_data)
  );

  // State register
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_fault != FLT_NONE)                 state_d = RESP;
          else if (in_req_we && in_req_size == SZ_D) state_d = WR;
          else                                       state_d = RD;
        end
      end
      RD:      state_d = req_we_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = in_resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    out_req_ready  = (state_q == IDLE);
    out_resp_valid = (state_q == RESP);
  end

  // Capture, memory-side and response registers
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      req_off_q      <= 3'd0;
      req_size_q     <= SZ_B;
      req_we_q       <= 1'b0;
      req_uns_q      <= 1'b0;
      req_wdata_q    <= 64'd0;
      out_mem_addr   <= 64'd0;
      out_mem_data   <= 64'd0;
      out_mem_wr_en  <= 1'b0;
      out_resp_rdata <= 64'd0;
      out_resp_fault <= FLT_NONE;
    end else begin
      // WR always lasts one cycle, so this yields a single-cycle strobe.
      out_mem_wr_en <= (state_d == WR);

      if (accept) begin
        req_off_q      <= in_req_addr[2:0];
        req_size_q     <= in_req_size;
        req_we_q       <= in_req_we;
        req_uns_q      <= in_req_unsigned;
        req_wdata_q    <= in_req_wdata;
        out_resp_rdata <= 64'd0;
        out_resp_fault <= req_fault;
        // Faulting requests leave the memory port untouched.
        if (req_fault == FLT_NONE) begin
          out_mem_addr <= {in_req_addr[63:3], 3'b000};
          if (in_req_we && in_req_size == SZ_D) out_mem_data <= in_req_wdata;
        end
      end

      // End of RD: the read doubleword is latched either as the merged store
      // image for WR or as the extended load result.
      if (state_q == RD) begin
        if (req_we_q) out_mem_data   <= store_data;
        else          out_resp_rdata <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Purpose: directed plus randomized checks of lsu_dmem_ctrl against a byte-array reference.
// Latency: checks accept->response cycle counts and the write-strobe cycle.
// Backpressure: exercises held in_resp_ready and a request pending behind it.
module tb_lsu_dmem_ctrl;

  localparam logic [63:0] MEM_BYTES = 64'd1048576;

  logic        in_clk = 1'b0;
  logic        in_rst = 1'b1;
  logic        in_req_valid = 1'b0;
  logic        out_req_ready;
  logic        in_req_we = 1'b0;
  logic [1:0]  in_req_size = 2'd0;
  logic        in_req_unsigned = 1'b0;
  logic [63:0] in_req_addr = 64'd0;
  logic [63:0] in_req_wdata = 64'd0;
  logic        out_resp_valid;
  logic        in_resp_ready = 1'b0;
  logic [63:0] out_resp_rdata;
  logic [1:0]  out_resp_fault;
  logic [63:0] out_mem_addr;
  logic [63:0] out_mem_data;
  logic        out_mem_wr_en;
  logic [63:0] in_mem_data;

  // Environment memory (doublewords) and independent byte-level reference.
  bit [63:0] mem [0:131071];
  bit [7:0]  rmem [0:1048575];
  logic        pre_we = 1'b0;
  logic [16:0] pre_idx = 17'd0;
  logic [63:0] pre_dat = 64'd0;

  int n_vec = 0;
  int n_err = 0;

  always #5 in_clk = ~in_clk;

  lsu_dmem_ctrl #(.DATA_WIDTH(64), .MEM_BYTES(MEM_BYTES)) dut (
    .in_clk          (in_clk),
    .in_rst          (in_rst),
    .in_req_valid    (in_req_valid),
    .out_req_ready   (out_req_ready),
    .in_req_we       (in_req_we),
    .in_req_size     (in_req_size),
    .in_req_unsigned (in_req_unsigned),
    .in_req_addr     (in_req_addr),
    .in_req_wdata    (in_req_wdata),
    .out_resp_valid  (out_resp_valid),
    .in_resp_ready   (in_resp_ready),
    .out_resp_rdata  (out_resp_rdata),
    .out_resp_fault  (out_resp_fault),
    .out_mem_addr    (out_mem_addr),
    .out_mem_data    (out_mem_data),
    .out_mem_wr_en   (out_mem_wr_en),
    .in_mem_data     (in_mem_data)
  );

  assign in_mem_data = mem[out_mem_addr[19:3]];

  always @(posedge in_clk) begin
    if (out_mem_wr_en) mem[out_mem_addr[19:3]] <= out_mem_data;
    else if (pre_we)   mem[pre_idx] <= pre_dat;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference rules written directly from the access semantics.
  function automatic logic [1:0] ref_fault(input logic [63:0] addr, input logic [1:0] size);
    longint unsigned n = 64'd1 << size;
    if ((addr % n) != 0) return 2'd1;
    if ((addr / 8) * 8 + 7 >= MEM_BYTES) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] addr, input logic [1:0] size, input logic uns);
    int n = 1 << size;
    logic [63:0] v = 64'd0;
    logic [63:0] ones = '1;
    for (int i = 0; i < n; i++) v = v | (64'(rmem[addr[19:0] + 20'(i)]) << (8 * i));
    if (!uns && size != 2'd3 && v[8*n-1]) v = v | (ones << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input logic [63:0] addr, input logic [1:0] size, input logic [63:0] wdata);
    int n = 1 << size;
    for (int i = 0; i < n; i++) rmem[addr[19:0] + 20'(i)] = wdata[8*i +: 8];
  endtask

  task automatic preload(input logic [63:0] addr, input logic [63:0] dat);
    pre_idx = addr[19:3];
    pre_dat = dat;
    pre_we  = 1'b1;
    @(posedge in_clk); #1;
    pre_we  = 1'b0;
    for (int i = 0; i < 8; i++) rmem[addr[19:0] + 20'(i)] = dat[8*i +: 8];
  endtask

  // One request from accept to completed response. 'pend' keeps the same
  // request asserted while the response is held, to probe back-to-back issue.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input int hold, input logic pend);
    logic [1:0]  exp_flt;
    logic [63:0] exp_rd;
    logic [63:0] exp_addr;
    logic [63:0] rd_seen;
    int exp_lat, exp_wr_at, exp_wr_cnt;
    int lat, wr_at, wr_cnt;

    exp_flt   = ref_fault(addr, size);
    exp_rd    = (exp_flt == 2'd0 && !we) ? ref_load(addr, size, uns) : 64'd0;
    exp_addr  = (exp_flt == 2'd0) ? (addr & ~64'd7) : out_mem_addr;
    exp_lat   = (exp_flt != 2'd0) ? 1 : (!we ? 2 : (size == 2'd3 ? 2 : 3));
    exp_wr_cnt = (we && exp_flt == 2'd0) ? 1 : 0;
    exp_wr_at = (exp_wr_cnt == 0) ? 0 : (size == 2'd3 ? 1 : 2);
    if (we && exp_flt == 2'd0) ref_store(addr, size, wdata);

    in_req_we = we; in_req_size = size; in_req_unsigned = uns;
    in_req_addr = addr; in_req_wdata = wdata; in_req_valid = 1'b1;
    @(posedge in_clk); #1;
    in_req_valid = 1'b0;

    lat = 1; wr_at = 0; wr_cnt = 0;
    while (1) begin
      if (out_mem_wr_en) begin wr_cnt++; wr_at = lat; end
      if (out_resp_valid || lat >= 10) break;
      @(posedge in_clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("rdata", out_resp_rdata, exp_rd);
    chk("fault", 64'(out_resp_fault), 64'(exp_flt));
    chk("wr_cycles", 64'(wr_cnt), 64'(exp_wr_cnt));
    chk("wr_cycle_at", 64'(wr_at), 64'(exp_wr_at));
    chk("mem_addr", out_mem_addr, exp_addr);

    rd_seen = out_resp_rdata;
    if (pend) in_req_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge in_clk); #1;
      chk("hold_valid", 64'(out_resp_valid), 64'd1);
      chk("hold_rdata", out_resp_rdata, rd_seen);
      chk("hold_req_ready", 64'(out_req_ready), 64'd0);
    end
    in_resp_ready = 1'b1;
    @(posedge in_clk); #1;
    in_resp_ready = 1'b0;
    chk("post_resp_valid", 64'(out_resp_valid), 64'd0);
    chk("post_req_ready", 64'(out_req_ready), 64'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 64'(out_req_ready), 64'd1);
    chk({tag, "_resp_valid"}, 64'(out_resp_valid), 64'd0);
    chk({tag, "_rdata"}, out_resp_rdata, 64'd0);
    chk({tag, "_fault"}, 64'(out_resp_fault), 64'd0);
    chk({tag, "_mem_addr"}, out_mem_addr, 64'd0);
    chk({tag, "_mem_data"}, out_mem_data, 64'd0);
    chk({tag, "_wr_en"}, 64'(out_mem_wr_en), 64'd0);
  endtask

  initial begin
    logic [63:0] a;
    logic [1:0]  sz;

    // Reset state
    repeat (3) @(posedge in_clk);
    #1;
    chk_reset_vals("rst");
    in_rst = 1'b0;
    @(posedge in_clk); #1;
    chk_reset_vals("post_rst");

    // Sign/zero-extended byte loads from the top lane
    preload(64'h100, 64'h8877665544332211);
    do_req(1'b0, 2'd0, 1'b0, 64'h107, 64'd0, 0, 1'b0);
    chk("tp_lb_signed", ref_load(64'h107, 2'd0, 1'b0), 64'hFFFFFFFFFFFFFF88);
    do_req(1'b0, 2'd0, 1'b1, 64'h107, 64'd0, 0, 1'b0);

    // Narrow store read-modify-write, then read back the doubleword
    do_req(1'b1, 2'd1, 1'b0, 64'h102, 64'h000000000000BEEF, 0, 1'b0);
    chk("tp_merge_mem", mem[32], 64'h88776655BEEF2211);
    do_req(1'b0, 2'd3, 1'b0, 64'h100, 64'd0, 0, 1'b0);

    // Double store skips the read
    do_req(1'b1, 2'd3, 1'b0, 64'h200, 64'h0123456789ABCDEF, 0, 1'b0);
    chk("tp_sd_mem", mem[64], 64'h0123456789ABCDEF);

    // Faults and the top-of-memory boundary
    do_req(1'b0, 2'd2, 1'b0, 64'h103, 64'd0, 0, 1'b0);
    do_req(1'b0, 2'd3, 1'b0, 64'hFFFF8, 64'd0, 0, 1'b0);
    do_req(1'b0, 2'd3, 1'b0, 64'h100000, 64'd0, 0, 1'b0);
    do_req(1'b1, 2'd3, 1'b0, 64'h100000, 64'hDEAD, 0, 1'b0);

    // Held response with a request waiting behind it
    do_req(1'b0, 2'd2, 1'b1, 64'h104, 64'd0, 5, 1'b1);
    do_req(1'b0, 2'd2, 1'b1, 64'h104, 64'd0, 0, 1'b0);

    // Reset asserted during the write cycle
    in_req_we = 1'b1; in_req_size = 2'd1; in_req_unsigned = 1'b0;
    in_req_addr = 64'h300; in_req_wdata = 64'h1234; in_req_valid = 1'b1;
    @(posedge in_clk); #1;
    in_req_valid = 1'b0;
    @(posedge in_clk); #1;
    chk("wr_before_rst", 64'(out_mem_wr_en), 64'd1);
    in_rst = 1'b1;
    #1;
    chk_reset_vals("mid_wr_rst");
    @(posedge in_clk); #1;
    in_rst = 1'b0;
    @(posedge in_clk); #1;
    chk_reset_vals("after_wr_rst");
    do_req(1'b0, 2'd3, 1'b0, 64'h300, 64'd0, 0, 1'b0);

    // Randomized mix over a small region and around the top of memory
    for (int k = 0; k < 200; k++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)
        a = MEM_BYTES - 64'(8 * $urandom_range(0, 2)) + 64'($urandom_range(0, 7));
      else
        a = 64'h1000 + 64'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
             {$urandom, $urandom}, $urandom_range(0, 2), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
